// File: rtl/dmem_responder.sv
// Data-memory responder for the CPU SRAM bus: word RAM plus a 16-byte MMIO window
// (cycle counter, LED register, sticky error status). Reads are combinational.
module dmem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned AW      = 8,
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] sramA,
  inout  wire  [31:0] sramData,
  input  logic        sramWe,
  input  logic        sramRe,
  output logic [31:0] led,
  output logic        err
);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   cnt_r;
  logic [2:0]    err_bits_r;
  logic [2:0]    err_next_s;
  logic          io_hit_s;
  logic          ram_hit_s;
  logic          misal_s;
  logic          rd_s;
  logic          wr_s;
  logic          both_s;
  logic          set_align_s;
  logic          set_range_s;
  logic          clr_s;
  logic          ram_we_s;
  logic          led_we_s;
  logic [AW-1:0] idx_s;
  logic [1:0]    io_off_s;
  logic [31:0]   rdata_s;
  logic          drive_s;

  // Address decode and per-cycle access classification.
  always_comb begin
    io_hit_s    = (sramA[31:4] == IO_BASE[31:4]);
    ram_hit_s   = !io_hit_s && (sramA[31:AW+2] == '0);
    idx_s       = sramA[AW+1:2];
    io_off_s    = sramA[3:2];
    misal_s     = (sramA[1:0] != 2'b00);
    rd_s        = sramRe && !sramWe;
    wr_s        = sramWe && !sramRe;
    both_s      = sramWe && sramRe;
    set_align_s = misal_s && (rd_s || wr_s);
    set_range_s = (sramWe || sramRe) && !ram_hit_s && !io_hit_s;
    clr_s       = wr_s && io_hit_s && !misal_s && (io_off_s == 2'd2);
    ram_we_s    = wr_s && ram_hit_s && !misal_s;
    led_we_s    = wr_s && io_hit_s && !misal_s && (io_off_s == 2'd1);
    drive_s     = rst && rd_s;
  end

  // A clear and a set never share a cycle in practice, but set still wins.
  always_comb begin
    if (clr_s) begin
      err_next_s = 3'b000;
    end else begin
      err_next_s = err_bits_r;
    end
    err_next_s = err_next_s | {both_s, set_range_s, set_align_s};
  end

  // Read data mux; misaligned reads use the truncated word index.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (ram_hit_s) begin
      rdata_s = mem[idx_s];
    end else if (io_hit_s) begin
      case (io_off_s)
        2'd0:    rdata_s = cnt_r;
        2'd1:    rdata_s = led;
        2'd2:    rdata_s = {29'b0, err_bits_r};
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign sramData = drive_s ? rdata_s : 32'bz;

  // RAM array, fully cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 32'h0000_0000;
      end
    end else if (ram_we_s) begin
      mem[idx_s] <= sramData;
    end
  end

  // Free-running cycle counter; wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 32'h0000_0000;
    end else begin
      cnt_r <= cnt_r + 32'd1;
    end
  end

  // LED output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led <= 32'h0000_0000;
    end else if (led_we_s) begin
      led <= sramData;
    end
  end

  // Sticky error bits and their registered summary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_bits_r <= 3'b000;
      err        <= 1'b0;
    end else begin
      err_bits_r <= err_next_s;
      err        <= |err_next_s;
    end
  end

endmodule
